// File: rtl/rom_arb_2x.sv
`default_nettype none
// ============================================================================
//  Module   : rom_arb_2x
//  Purpose  : Two-port round-robin arbiter in front of one shared synchronous
//             ROM. Each grant takes three cycles: arbitrate, read, capture.
//  Revision : 1.0  initial release
// ============================================================================
module rom_arb_2x #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_gnt;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_busy;

    logic [1:0]        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_last_gnt_nxt;
    logic              w_gnt0_nxt;
    logic              w_gnt1_nxt;
    logic              w_rvalid0_nxt;
    logic              w_rvalid1_nxt;
    logic [DATA_W-1:0] w_rdata0_nxt;
    logic [DATA_W-1:0] w_rdata1_nxt;
    logic              w_rom_en_nxt;
    logic [ADDR_W-1:0] w_rom_addr_nxt;
    logic              w_busy_nxt;
    logic              w_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;   // port 0 takes the first tie
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_gnt0     <= w_gnt0_nxt;
            r_gnt1     <= w_gnt1_nxt;
            r_rvalid0  <= w_rvalid0_nxt;
            r_rvalid1  <= w_rvalid1_nxt;
            r_rdata0   <= w_rdata0_nxt;
            r_rdata1   <= w_rdata1_nxt;
            r_rom_en   <= w_rom_en_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_gnt_nxt = r_last_gnt;
        w_gnt0_nxt     = 1'b0;
        w_gnt1_nxt     = 1'b0;
        w_rvalid0_nxt  = 1'b0;
        w_rvalid1_nxt  = 1'b0;
        w_rdata0_nxt   = r_rdata0;
        w_rdata1_nxt   = r_rdata1;
        w_rom_en_nxt   = 1'b0;
        w_rom_addr_nxt = r_rom_addr;
        // A lone requester wins outright; a tie goes to the port not granted last.
        w_winner       = (req0 && req1) ? ~r_last_gnt : req1;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt    = S_READ;
                    w_rom_en_nxt   = 1'b1;
                    w_rom_addr_nxt = w_winner ? addr1 : addr0;
                    w_gnt0_nxt     = ~w_winner;
                    w_gnt1_nxt     = w_winner;
                    w_owner_nxt    = w_winner;
                    w_last_gnt_nxt = w_winner;
                end
            end
            S_READ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_IDLE;
                if (r_owner) begin
                    w_rdata1_nxt  = rom_data;
                    w_rvalid1_nxt = 1'b1;
                end else begin
                    w_rdata0_nxt  = rom_data;
                    w_rvalid0_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rom_arb_2x.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_arb_2x
//  Purpose  : Directed and random stimulus for rom_arb_2x against a
//             transaction-timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_arb_2x;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [16];

    rom_arb_2x #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    // Reference model: a read accepted at edge e shows gnt/rom_en in the cycle
    // after e, rvalid after edge e+2, and the next arbitration is at edge e+3.
    int            edge_n;
    int            m_next_arb, m_gnt_cyc, m_rv_cyc;
    bit            m_port, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rd0, m_rd1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0; m_next_arb = 0; m_gnt_cyc = -10; m_rv_cyc = -10;
            m_port = 0; m_last = 1; m_addr = '0; m_rd0 = '0; m_rd1 = '0;
        end else begin
            edge_n++;
            if (edge_n == m_rv_cyc) begin
                if (m_port) m_rd1 = mem[m_addr];
                else        m_rd0 = mem[m_addr];
            end
            if (edge_n >= m_next_arb && (req0 || req1)) begin
                m_port     = (req0 && req1) ? !m_last : req1;
                m_last     = m_port;
                m_addr     = m_port ? addr1 : addr0;
                m_gnt_cyc  = edge_n;
                m_rv_cyc   = edge_n + 2;
                m_next_arb = edge_n + 3;
            end
        end
    end

    int gnt_port_q[$];
    int gnt_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_model();
        logic g, rv;
        g  = (edge_n == m_gnt_cyc);
        rv = (edge_n == m_rv_cyc);
        chk("gnt0",    32'(gnt0),    32'(g && !m_port));
        chk("gnt1",    32'(gnt1),    32'(g && m_port));
        chk("rom_en",  32'(rom_en),  32'(g));
        chk("rom_addr",32'(rom_addr),32'(m_addr));
        chk("busy",    32'(busy),    32'(g || edge_n == m_gnt_cyc + 1));
        chk("rvalid0", 32'(rvalid0), 32'(rv && !m_port));
        chk("rvalid1", 32'(rvalid1), 32'(rv && m_port));
        chk("rdata0",  32'(rdata0),  32'(m_rd0));
        chk("rdata1",  32'(rdata1),  32'(m_rd1));
    endtask

    // One clock: sample at the falling edge, then the requester drops a granted request.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
        if (gnt0) begin gnt_port_q.push_back(0); gnt_cyc_q.push_back(edge_n); end
        if (gnt1) begin gnt_port_q.push_back(1); gnt_cyc_q.push_back(edge_n); end
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_rom_en", 32'(rom_en),  32'd0);
        chk("rst_rvalid0",32'(rvalid0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (2) @(negedge clk);
        check_model();
        chk("reset_rdata0", 32'(rdata0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single port 0 read of address 3
        addr0 = 4'd3; req0 = 1'b1;
        tick();
        chk("d1_gnt0", 32'(gnt0), 32'd1);
        chk("d1_rom_addr", 32'(rom_addr), 32'd3);
        tick(); tick();
        chk("d1_rvalid0", 32'(rvalid0), 32'd1);
        chk("d1_rdata0", 32'(rdata0), 32'h0103);
        chk("d1_rdata1", 32'(rdata1), 32'd0);
        tick();

        // Tie right after reset: port 0 first, then port 1
        do_reset();
        addr0 = 4'd5; addr1 = 4'd9; req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("d2_gnt0", 32'(gnt0), 32'd1);
        tick(); tick();
        chk("d2_rdata0", 32'(rdata0), 32'h0105);
        tick();
        chk("d2_gnt1", 32'(gnt1), 32'd1);
        tick(); tick();
        chk("d2_rvalid1", 32'(rvalid1), 32'd1);
        chk("d2_rdata1", 32'(rdata1), 32'h0109);
        tick();

        // Continuous dual requests: strict alternation, 3 cycles apart
        gnt_port_q.delete(); gnt_cyc_q.delete();
        req0 = 1'b1; req1 = 1'b1;
        while (gnt_port_q.size() < 6 && edge_n < 200) begin
            tick();
            if (!req0 && !gnt0) begin addr0 = 4'($urandom); req0 = 1'b1; end
            if (!req1 && !gnt1) begin addr1 = 4'($urandom); req1 = 1'b1; end
        end
        chk("d3_count", 32'(gnt_port_q.size() >= 6), 32'd1);
        first = gnt_cyc_q.size() > 0 ? gnt_cyc_q[0] : 0;
        for (int i = 0; i < 6 && i < gnt_port_q.size(); i++) begin
            chk($sformatf("d3_order%0d", i), 32'(gnt_port_q[i]), 32'(i % 2));
            chk($sformatf("d3_space%0d", i), 32'(gnt_cyc_q[i] - first), 32'(3 * i));
        end
        while ((req0 || req1) && edge_n < 400) tick();
        repeat (3) tick();

        // Port 1 raises during gnt0; served at the edge after rvalid0, address 15
        addr0 = 4'd2; req0 = 1'b1;
        tick();
        chk("d4_gnt0", 32'(gnt0), 32'd1);
        addr1 = 4'd15; req1 = 1'b1;
        tick(); tick();
        chk("d4_rvalid0", 32'(rvalid0), 32'd1);
        tick();
        chk("d4_gnt1", 32'(gnt1), 32'd1);
        chk("d4_rom_addr", 32'(rom_addr), 32'd15);
        tick(); tick();
        chk("d4_rdata1", 32'(rdata1), 32'h010F);
        tick();

        // Reset during WAIT of a port 0 read aborts it
        addr0 = 4'd7; req0 = 1'b1;
        tick(); tick();
        chk("d5_wait_busy", 32'(busy), 32'd1);
        do_reset();
        repeat (4) tick();
        chk("d5_rvalid0", 32'(rvalid0), 32'd0);
        addr0 = 4'd1; addr1 = 4'd2; req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("d5_tie_gnt0", 32'(gnt0), 32'd1);
        while ((req0 || req1) && edge_n < 100) tick();
        repeat (3) tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            tick();
            if (!req0 && !gnt0 && $urandom_range(0, 2) == 0) begin addr0 = 4'($urandom); req0 = 1'b1; end
            if (!req1 && !gnt1 && $urandom_range(0, 2) == 0) begin addr1 = 4'($urandom); req1 = 1'b1; end
        end
        repeat (8) tick();
        chk("rand_drained", 32'(req0 || req1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_arb_2x.md
ROM_ARB_2X -- requirements
Module: rom_arb_2x

Interface
REQ-001 Parameter ADDR_W, default 4, ROM address width (depth = 2**ADDR_W = 16).
REQ-002 Parameter DATA_W, default 16, ROM data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0  input  1  port 0 read request; held high until gnt0 seen, low in the cycle after gnt0.
REQ-006 addr0  input  ADDR_W  port 0 read address; stable while req0 high.
REQ-007 gnt0  output  1  one-cycle pulse: port 0 request accepted.
REQ-008 rvalid0  output  1  one-cycle pulse: rdata0 carries port 0 result.
REQ-009 rdata0  output  DATA_W  port 0 read data; holds last value between responses.
REQ-010 req1, addr1, gnt1, rvalid1, rdata1  same directions, widths and meaning as port 0, for port 1.
REQ-011 rom_en  output  1  read strobe to the shared synchronous ROM.
REQ-012 rom_addr  output  ADDR_W  address to the shared ROM.
REQ-013 rom_data  input  DATA_W  ROM output; valid the cycle after the edge that samples rom_en=1.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 All outputs are registered; no combinational path from any input to any output.
REQ-016 FSM states IDLE, READ, WAIT; transitions IDLE->READ on any request, READ->WAIT unconditionally, WAIT->IDLE unconditionally.
REQ-017 IDLE, edge with no req: remain IDLE, all strobes low.
REQ-018 IDLE, edge with exactly one req high: that port wins regardless of priority pointer.
REQ-019 IDLE, edge with req0 and req1 both high: winner is the port not granted last (pointer last_gnt); only one winner per arbitration.
REQ-020 On winning edge: rom_addr <= winner address, rom_en <= 1, gnt<winner> <= 1, owner <= winner, last_gnt <= winner, state <= READ.
REQ-021 READ edge: rom_en <= 0, gnt0/gnt1 <= 0, state <= WAIT; requests ignored.
REQ-022 WAIT edge: rdata<owner> <= rom_data, rvalid<owner> <= 1, state <= IDLE; other port's rdata unchanged.
REQ-023 rvalid pulses clear on the next edge; rvalid0 and rvalid1 never high together; gnt0 and gnt1 never high together.
REQ-024 Latency: request sampled at edge T -> gnt high cycle T+1 -> rvalid high cycle T+3; next arbitration at edge T+3; max throughput one read per 3 cycles.
REQ-025 A request arriving while busy is held by the requester and arbitrated at the next IDLE edge; no request is lost.
REQ-026 Under continuous dual requests, grants strictly alternate 0,1,0,1,...
REQ-027 rom_addr holds its value outside READ; rom_en high exactly one cycle per grant.
REQ-028 busy high in cycles where state is READ or WAIT.

Reset
REQ-029 rst_n low asynchronously forces: state IDLE, rom_en 0, rom_addr 0, gnt0/gnt1 0, rvalid0/rvalid1 0, rdata0/rdata1 0, busy 0, owner 0, last_gnt 1 (port 0 wins first tie).
REQ-030 Reset during READ or WAIT aborts the transaction; no rvalid is produced for it after release.
REQ-031 First arbitration is on the first rising edge with rst_n high.

Verification
REQ-032 ROM preloaded mem[i]=16'h0100+i; req0=1 addr0=3 alone -> gnt0 cycle T+1, rom_en=1 rom_addr=3 cycle T+1, rvalid0=1 rdata0=16'h0103 cycle T+3, rdata1 stays 0.
REQ-033 After reset, req0 (addr 5) and req1 (addr 9) same edge -> port 0 served first (rdata0=16'h0105), then port 1 at next IDLE edge (rdata1=16'h0109, rvalid1 3 cycles after rvalid0).
REQ-034 Both ports requesting continuously for 6 grants -> grant order 0,1,0,1,0,1; gnt pulses exactly 3 cycles apart.
REQ-035 req1 (addr 15) raised in the cycle gnt0 is high -> gnt1 at cycle after rvalid0 edge; rdata1=16'h010F; wrap address 15 handled.
REQ-036 rst_n pulsed low during WAIT of a port 0 read -> busy, rom_en, rvalid0 0 immediately; no rvalid0 after release; next tie goes to port 0.
